// File: rtl/pe2s_tx_if.sv
// pe2s_tx_if: PE-side request/payload and router-side flit handshake bundle for pe2s_tx
interface pe2s_tx_if;
  logic        start;
  logic [1:0]  dest_x;
  logic [1:0]  dest_y;
  logic [3:0]  body_len;
  logic [29:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        grant;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        busy;
  logic        done;
  logic        finish_in;
  logic        result_in;
  logic        resp_ok;
  logic        timeout;
  modport master (
    output start, dest_x, dest_y, body_len, data_in, data_valid, grant, finish_in, result_in,
    input  data_ready, flit_out, flit_valid, busy, done, resp_ok, timeout
  );
  modport slave (
    input  start, dest_x, dest_y, body_len, data_in, data_valid, grant, finish_in, result_in,
    output data_ready, flit_out, flit_valid, busy, done, resp_ok, timeout
  );
endinterface

// File: rtl/pe2s_tx.sv
// pe2s_tx: PE-to-router packetizer (header/body/tail flits); define RESP_WAIT_EN to wait for the returning handshake
module pe2s_tx #(
  parameter logic [1:0] SRC_X = 2'd0,
  parameter logic [1:0] SRC_Y = 2'd0,
  parameter int MAX_BODY = 15,
  parameter int RESP_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  pe2s_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HEAD, BODY, TAIL, WAIT_RESP} state_t;
  localparam logic [3:0] MAX_L = 4'(MAX_BODY);
  state_t state, nxt;
  logic [31:0] flit_q;
  logic vld_q, done_q;
  logic [3:0] len_q, rem_q, len_c;
  logic [15:0] csum_q;
  logic [17:0] seq_q;
  logic xfer, take, load_hdr, load_tail, clr_vld, fin;
`ifdef RESP_WAIT_EN
  localparam int CW = $clog2(RESP_TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic ok_q, to_q;
`endif
  assign len_c = (bus.body_len > MAX_L) ? MAX_L : bus.body_len;
  assign xfer = vld_q & bus.grant;
  assign bus.data_ready = (state == BODY) && (~vld_q | bus.grant) && (rem_q != 4'd0);
  assign take = bus.data_ready & bus.data_valid;
  assign bus.flit_out = flit_q;
  assign bus.flit_valid = vld_q;
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state and datapath load strobes; a flit only moves on valid && grant
  always_comb begin
    nxt = state;
    load_hdr = 1'b0;
    load_tail = 1'b0;
    clr_vld = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        nxt = HEAD;
        load_hdr = 1'b1;
      end
      HEAD: if (xfer) begin
        nxt = (len_q != 4'd0) ? BODY : TAIL;
        load_tail = len_q == 4'd0;
        clr_vld = len_q != 4'd0;
      end
      BODY: if (!take && xfer) begin
        nxt = (rem_q == 4'd0) ? TAIL : BODY;
        load_tail = rem_q == 4'd0;
        clr_vld = rem_q != 4'd0;
      end
      TAIL: if (xfer) begin
        clr_vld = 1'b1;
`ifdef RESP_WAIT_EN
        nxt = WAIT_RESP;
`else
        nxt = IDLE;
        fin = 1'b1;
`endif
      end
`ifdef RESP_WAIT_EN
      WAIT_RESP: if (bus.finish_in || cnt_q == CW'(RESP_TIMEOUT)) begin
        nxt = IDLE;
        fin = 1'b1;
      end
`endif
      default: nxt = IDLE;
    endcase
  end
  // output flit register, body bookkeeping and running checksum
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flit_q <= '0;
      vld_q <= 1'b0;
      done_q <= 1'b0;
      len_q <= '0;
      rem_q <= '0;
      csum_q <= '0;
      seq_q <= '0;
    end else begin
      done_q <= fin;
      if (load_hdr) begin
        flit_q <= {2'b10, bus.dest_x, bus.dest_y, SRC_X, SRC_Y, len_c, seq_q};
        vld_q <= 1'b1;
        len_q <= len_c;
        rem_q <= len_c;
        csum_q <= '0;
      end else if (take) begin
        flit_q <= {2'b01, bus.data_in};
        vld_q <= 1'b1;
        rem_q <= rem_q - 4'd1;
        csum_q <= csum_q ^ bus.data_in[15:0];
      end else if (load_tail) flit_q <= {2'b11, 10'b0, len_q, csum_q};
      else if (clr_vld) vld_q <= 1'b0;
      if (state == TAIL && xfer) seq_q <= seq_q + 18'd1;
    end
`ifdef RESP_WAIT_EN
  // response-wait cycle counter and handshake outcome
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      ok_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= (state == WAIT_RESP) ? cnt_q + 1'b1 : '0;
      to_q <= (state == WAIT_RESP) && !bus.finish_in && cnt_q == CW'(RESP_TIMEOUT);
      if (state == WAIT_RESP && bus.finish_in) ok_q <= bus.result_in;
      else if (state == WAIT_RESP && cnt_q == CW'(RESP_TIMEOUT)) ok_q <= 1'b0;
    end
  assign bus.resp_ok = ok_q;
  assign bus.timeout = to_q;
`else
  assign bus.resp_ok = 1'b0;
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pe2s_tx.sv
// tb_pe2s_tx: randomized self-checking bench for pe2s_tx against a packet-level flit model
module tb_pe2s_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pe2s_tx_if ifc();
  pe2s_tx dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  always #5 clk = ~clk;
  int n_pass = 0;
  int n_tot = 0;
  logic [17:0] exp_seq = '0;
  logic [29:0] words[$];
  logic [31:0] got[$];
  logic [31:0] expq[$];
  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(30'($urandom));
  endtask
  task automatic run_packet(input logic [1:0] dx, input logic [1:0] dy, input int dv_pct,
                            input int gr_pct, input int stall, input int abort_at, input bit noise);
    int wi, stall_left, n;
    bit seen_done, prev_stall;
    logic [31:0] prev_flit;
    logic [15:0] cs;
    logic [3:0] blen;
    n = words.size();
    blen = 4'(n);
    cs = '0;
    foreach (words[i]) cs ^= words[i][15:0];
    expq.delete();
    got.delete();
    expq.push_back({2'b10, dx, dy, 4'b0000, blen, exp_seq});
    foreach (words[i]) expq.push_back({2'b01, words[i]});
    expq.push_back({2'b11, 10'b0, blen, cs});
    wi = 0;
    seen_done = 0;
    prev_stall = 0;
    prev_flit = '0;
    stall_left = stall;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      @(posedge clk);
      #1;
      if (abort_at > 0 && got.size() == abort_at) begin
        rst_n = 1'b0;
        #1;
        n_tot++;
        if (ifc.flit_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.flit_out !== 32'h0) begin
          $display("FAIL async_reset: valid=%b busy=%b flit=%h want 0/0/0", ifc.flit_valid, ifc.busy, ifc.flit_out);
        end else n_pass++;
        ifc.start = 1'b0;
        ifc.data_valid = 1'b0;
        ifc.grant = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_seq = '0;
        return;
      end
      if (cyc == 0) begin
        ifc.start = 1'b1;
        ifc.dest_x = dx;
        ifc.dest_y = dy;
        ifc.body_len = blen;
      end else if (noise && got.size() < expq.size()) begin
        ifc.start = 1'($urandom_range(0, 1));
        ifc.dest_x = 2'($urandom);
        ifc.dest_y = 2'($urandom);
        ifc.body_len = 4'($urandom);
      end else ifc.start = 1'b0;
      if (stall_left > 0 && got.size() == 2 && ifc.flit_valid) begin
        ifc.grant = 1'b0;
        stall_left--;
      end else ifc.grant = $urandom_range(0, 99) < gr_pct;
      if (wi < n) begin
        ifc.data_valid = $urandom_range(0, 99) < dv_pct;
        ifc.data_in = words[wi];
      end else begin
        ifc.data_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        ifc.data_in = 30'($urandom);
      end
      @(negedge clk);
      if (cyc == 0) begin
        n_tot++;
        if (ifc.done !== 1'b0 || ifc.flit_valid !== 1'b0) begin
          $display("FAIL pre_start: done=%b valid=%b want 0/0", ifc.done, ifc.flit_valid);
        end else n_pass++;
      end
      if (cyc == 1) begin
        n_tot++;
        if (ifc.flit_valid !== 1'b1 || ifc.busy !== 1'b1 || ifc.flit_out !== expq[0]) begin
          $display("FAIL header_latency: valid=%b busy=%b flit=%h want 1/1/%h", ifc.flit_valid, ifc.busy, ifc.flit_out, expq[0]);
        end else n_pass++;
      end
      if (prev_stall) begin
        n_tot++;
        if (ifc.flit_valid !== 1'b1 || ifc.flit_out !== prev_flit) begin
          $display("FAIL hold: valid=%b flit=%h want 1/%h", ifc.flit_valid, ifc.flit_out, prev_flit);
        end else n_pass++;
      end
      if (ifc.flit_valid === 1'b1 && ifc.grant === 1'b0) begin
        n_tot++;
        if (ifc.data_ready !== 1'b0) $display("FAIL ready_in_stall: data_ready=%b want 0", ifc.data_ready);
        else n_pass++;
      end
      prev_stall = ifc.flit_valid === 1'b1 && ifc.grant === 1'b0;
      prev_flit = ifc.flit_out;
      if (ifc.data_valid && ifc.data_ready === 1'b1) begin
        n_tot++;
        if (wi >= n) $display("FAIL extra_word: accepted word %0d of %0d", wi, n);
        else n_pass++;
        wi++;
      end
      if (ifc.flit_valid === 1'b1 && ifc.grant) got.push_back(ifc.flit_out);
      if (ifc.done === 1'b1) begin
        seen_done = 1;
        n_tot++;
        if (ifc.busy !== 1'b0 || ifc.resp_ok !== 1'b0 || ifc.timeout !== 1'b0 || ifc.flit_valid !== 1'b0) begin
          $display("FAIL done_state: busy=%b resp_ok=%b timeout=%b valid=%b want 0/0/0/0", ifc.busy, ifc.resp_ok, ifc.timeout, ifc.flit_valid);
        end else n_pass++;
      end
    end
    n_tot++;
    if (!seen_done) $display("FAIL done_timeout: no done within 3000 cycles, got %0d flits want %0d", got.size(), expq.size());
    else n_pass++;
    n_tot++;
    if (got.size() != expq.size() || wi != n) begin
      $display("FAIL flit_count: got %0d flits/%0d words want %0d/%0d", got.size(), wi, expq.size(), n);
    end else n_pass++;
    foreach (expq[i]) if (i < got.size()) begin
      n_tot++;
      if (got[i] !== expq[i]) $display("FAIL flit[%0d]: got %h want %h", i, got[i], expq[i]);
      else n_pass++;
    end
    if (seen_done) exp_seq = exp_seq + 18'd1;
  endtask
  task automatic test_reset;
    ifc.start = 1'b0;
    ifc.dest_x = '0;
    ifc.dest_y = '0;
    ifc.body_len = '0;
    ifc.data_in = '0;
    ifc.data_valid = 1'b0;
    ifc.grant = 1'b0;
    ifc.finish_in = 1'b0;
    ifc.result_in = 1'b0;
    rst_n = 1'b0;
    #23;
    n_tot++;
    if ({ifc.flit_out, ifc.flit_valid, ifc.busy, ifc.done, ifc.data_ready, ifc.resp_ok, ifc.timeout} !== 38'h0) begin
      $display("FAIL reset_outputs: flit=%h valid=%b busy=%b done=%b ready=%b ok=%b to=%b want all 0",
               ifc.flit_out, ifc.flit_valid, ifc.busy, ifc.done, ifc.data_ready, ifc.resp_ok, ifc.timeout);
    end else n_pass++;
    rst_n = 1'b1;
    exp_seq = '0;
  endtask
  task automatic test_zero_body;
    words.delete();
    run_packet(2'd2, 2'd1, 100, 100, 0, 0, 0);
    n_tot++;
    if (got.size() < 2 || got[0] !== 32'hA400_0000 || got[1] !== 32'hC000_0000) begin
      $display("FAIL zero_body: got %0d flits, first %h want A4000000 then C0000000", got.size(), got.size() > 0 ? got[0] : 32'hx);
    end else n_pass++;
  endtask
  task automatic test_body3;
    words.delete();
    words.push_back(30'h1234);
    words.push_back(30'h0F0F);
    words.push_back(30'h0001);
    run_packet(2'd1, 2'd2, 100, 100, 0, 0, 0);
    n_tot++;
    if (got.size() != 5 || got[4] !== 32'hC003_1D3A) begin
      $display("FAIL body3_tail: got %0d flits, tail %h want 5 flits, C0031D3A", got.size(), got.size() == 5 ? got[4] : 32'hx);
    end else n_pass++;
  endtask
  task automatic test_grant_stall;
    fill_words(4);
    run_packet(2'd0, 2'd3, 100, 100, 5, 0, 0);
  endtask
  task automatic test_data_gaps;
    fill_words(15);
    run_packet(2'd3, 2'd3, 35, 100, 0, 0, 0);
  endtask
  task automatic test_ignored_inputs;
    fill_words(6);
    run_packet(2'd1, 2'd1, 60, 70, 0, 0, 1);
  endtask
  task automatic test_reset_mid_body;
    fill_words(5);
    run_packet(2'd2, 2'd2, 100, 100, 0, 2, 0);
    fill_words(2);
    run_packet(2'd0, 2'd1, 100, 100, 0, 0, 0);
    n_tot++;
    if (got.size() == 0 || got[0][17:0] !== 18'h0) begin
      $display("FAIL seq_after_reset: got %h want seq 0", got.size() > 0 ? got[0] : 32'hx);
    end else n_pass++;
  endtask
  task automatic test_back_to_back;
    for (int p = 0; p < 10; p++) begin
      fill_words($urandom_range(0, 15));
      run_packet(2'($urandom), 2'($urandom), $urandom_range(40, 100), $urandom_range(40, 100), 0, 0, p[0]);
    end
  endtask
  initial begin
    test_reset();
    test_zero_body();
    test_body3();
    test_grant_stall();
    test_data_gaps();
    test_ignored_inputs();
    test_reset_mid_body();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
